// File: rtl/note_detector.sv
// note_detector: times the squared-up mic period and reports one of eight notes (C4..C5) one-hot.
// Latency: 4 clk from an audio_sq rise to a note_array/note_new change; free-running, no backpressure.
// NOTE_HOLD_EN defined: the last note stays displayed across a silence timeout instead of clearing.
`timescale 1ns/1ps
module note_detector #(
    parameter int CNT_W      = 18,
    parameter int STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       audio_sq,
    output logic [7:0] note_array,
    output logic       note_new
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [3:0]       STABLE  = 4'(STABLE_CNT);

    // Bins tile the period axis, so each lower edge is the next shorter note's upper edge.
    localparam logic [CNT_W-1:0] C5_LO = CNT_W'(92715);
    localparam logic [CNT_W-1:0] B4_LO = CNT_W'(98397);
    localparam logic [CNT_W-1:0] A4_LO = CNT_W'(107437);
    localparam logic [CNT_W-1:0] G4_LO = CNT_W'(120593);
    localparam logic [CNT_W-1:0] F4_LO = CNT_W'(135361);
    localparam logic [CNT_W-1:0] E4_LO = CNT_W'(147428);
    localparam logic [CNT_W-1:0] D4_LO = CNT_W'(160975);
    localparam logic [CNT_W-1:0] C4_LO = CNT_W'(180689);
    localparam logic [CNT_W-1:0] C4_HI = CNT_W'(201537);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sync1;
    logic             sync2;
    logic             sync2_q;
    logic             edge_det;
    logic [7:0]       cand;
    logic [3:0]       match_cnt;
    logic [7:0]       bin;
    logic [3:0]       next_match;

    function automatic logic in_bin(input logic [CNT_W-1:0] p,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
        return (p >= lo) && (p < hi);
    endfunction

    // cnt holds the period length exactly in the cycle edge_det is seen.
    assign bin = {in_bin(cnt, C5_LO, B4_LO),
                  in_bin(cnt, B4_LO, A4_LO),
                  in_bin(cnt, A4_LO, G4_LO),
                  in_bin(cnt, G4_LO, F4_LO),
                  in_bin(cnt, F4_LO, E4_LO),
                  in_bin(cnt, E4_LO, D4_LO),
                  in_bin(cnt, D4_LO, C4_LO),
                  in_bin(cnt, C4_LO, C4_HI)};

    always_comb begin
        next_match = 4'd1;
        if (bin == cand) begin
            next_match = (match_cnt >= STABLE) ? STABLE : match_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync2_q  <= 1'b0;
            edge_det <= 1'b0;
        end else begin
            sync1    <= audio_sq;
            sync2    <= sync1;
            sync2_q  <= sync2;
            edge_det <= sync2 & ~sync2_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cand       <= 8'h00;
            match_cnt  <= 4'd0;
            note_array <= 8'h00;
            note_new   <= 1'b0;
        end else begin
            note_new <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (edge_det) begin
                        state <= MEASURE;
                        cnt   <= CNT_ONE;
                    end
                end
                MEASURE: begin
                    // An edge coinciding with saturation wins; its period is out of range anyway.
                    if (edge_det) begin
                        cnt <= CNT_ONE;
                        if (bin == 8'h00) begin
                            cand      <= 8'h00;
                            match_cnt <= 4'd0;
                        end else begin
                            cand      <= bin;
                            match_cnt <= next_match;
                            if (next_match == STABLE && bin != note_array) begin
                                note_array <= bin;
                                note_new   <= 1'b1;
                            end
                        end
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        cand      <= 8'h00;
                        match_cnt <= 4'd0;
`ifdef NOTE_HOLD_EN
`else
                        if (note_array != 8'h00) begin
                            note_array <= 8'h00;
                            note_new   <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector: note-level reference model feeds a scoreboard of expected output changes.
`timescale 1ns/1ps
module tb_note_detector;
    localparam int CNT_MAX = 262143;
    localparam int STABLE  = 4;
`ifdef NOTE_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b0;
    logic       audio_sq = 1'b0;
    logic [7:0] note_array;
    logic       note_new;

    note_detector #(.CNT_W(18), .STABLE_CNT(STABLE)) dut (
        .clk       (clk),
        .reset     (reset),
        .audio_sq  (audio_sq),
        .note_array(note_array),
        .note_new  (note_new)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    // Reference model: note index 0..7 = C4..C5, period bins in clocks.
    int bin_lo[8] = '{180689, 160975, 147428, 135361, 120593, 107437, 98397, 92715};
    int bin_hi[8] = '{201537, 180689, 160975, 147428, 135361, 120593, 107437, 98397};
    bit         meas   = 1'b0;
    int         last_t = 0;
    int         cand   = -1;
    int         run    = 0;
    logic [7:0] shown  = 8'h00;

    function automatic int classify(input int p);
        for (int i = 0; i < 8; i++)
            if (p >= bin_lo[i] && p < bin_hi[i]) return i;
        return -1;
    endfunction

    task automatic push_exp(input int c, input logic [7:0] v);
        exp_t e;
        e.cyc = c;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic model_timeout(input int c);
        meas = 1'b0;
        cand = -1;
        run  = 0;
        if (!HOLD && shown != 8'h00) begin
            shown = 8'h00;
            push_exp(c, 8'h00);
        end
    endtask

    // t0: first cycle whose rising clock samples audio_sq high; outputs react 3 cycles later.
    task automatic model_rise(input int t0);
        int p;
        int b;
        if (meas && (t0 - last_t) > CNT_MAX) model_timeout(last_t + 3 + CNT_MAX);
        if (meas) begin
            p = t0 - last_t;
            b = classify(p);
            if (b < 0) begin
                cand = -1;
                run  = 0;
            end else begin
                if (b == cand) run = (run < STABLE) ? run + 1 : STABLE;
                else begin
                    cand = b;
                    run  = 1;
                end
                if (run == STABLE && shown != 8'(1 << b)) begin
                    shown = 8'(1 << b);
                    push_exp(t0 + 3, shown);
                end
            end
        end
        meas   = 1'b1;
        last_t = t0;
    endtask

    task automatic model_reset();
        meas  = 1'b0;
        cand  = -1;
        run   = 0;
        shown = 8'h00;
        sb.delete();
    endtask

    // Monitor: every output pulse must match the head of the scoreboard, on time.
    initial begin : monitor
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                vectors++;
                miscompares++;
                $display("FAIL missed_change: no note_new by cycle %0d, required note_array=%h at cycle %0d",
                         cyc, sb[0].val, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (note_new === 1'b1) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_pulse: note_new=1 note_array=%h at cycle %0d, required no pulse",
                             note_array, cyc);
                end else begin
                    if (sb[0].cyc != cyc || sb[0].val !== note_array) begin
                        miscompares++;
                        $display("FAIL note_change: got note_array=%h at cycle %0d, required %h at cycle %0d",
                                 note_array, cyc, sb[0].val, sb[0].cyc);
                    end
                    void'(sb.pop_front());
                end
            end
        end
    end

    // All stimulus waits start and end on a falling clock edge.
    task automatic wait_cyc(input int n);
        #(10 * n);
    endtask

    task automatic check_state(input string name);
        vectors++;
        if (note_array !== shown) begin
            miscompares++;
            $display("FAIL %s: note_array=%h at cycle %0d, required %h", name, note_array, cyc, shown);
        end
    endtask

    task automatic check_zero(input string name);
        vectors++;
        if (note_array !== 8'h00 || note_new !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: note_array=%h note_new=%b, required 00 and 0", name, note_array, note_new);
        end
    endtask

    task automatic rise(input string name);
        audio_sq = 1'b1;
        model_rise(cyc + 1);
        wait_cyc(8);
        check_state(name);
    endtask

    // One rise followed by a gap of p clocks to the next rise, random duty cycle.
    task automatic run_period(input int p, input string name);
        int hi_len;
        rise(name);
        hi_len = int'($urandom_range(p / 4, 3 * p / 4));
        wait_cyc(hi_len - 8);
        audio_sq = 1'b0;
        wait_cyc(p - hi_len);
    endtask

    task automatic run_period_reset(input int p);
        rise("locked_before_reset");
        wait_cyc(p / 2 - 8);
        audio_sq = 1'b0;
        wait_cyc(int'($urandom_range(10, 200)) + 0);
        reset = 1'b0;
        #1;
        check_zero("reset_async_clear");
        model_reset();
        #9;
        reset = 1'b1;
        wait_cyc(p / 2 - 400);
    endtask

    function automatic int rnd_c5();
        return int'($urandom_range(92715, 98396));
    endfunction

    initial begin : stimulus
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            audio_sq = ~audio_sq;
            wait_cyc(2);
            check_zero("held_in_reset");
        end
        audio_sq = 1'b0;
        wait_cyc(4);
        reset = 1'b1;
        wait_cyc(10);

        for (int i = 0; i < 5; i++) run_period(113636, "a4_lock");
        for (int i = 0; i < 4; i++) run_period(95556, "a4_to_c5");
        for (int i = 0; i < 4; i++) run_period(180689, "c4_low_edge");
        run_period(180688, "d4_high_edge");
        for (int i = 0; i < 3; i++) run_period(int'($urandom_range(160975, 180688)), "d4_lock");
        for (int i = 0; i < 3; i++) run_period(rnd_c5(), "c5_before_short");
        run_period(50000, "short_period");
        for (int i = 0; i < 3; i++) run_period(rnd_c5(), "c5_after_short");
        run_period(92714, "c5_low_edge_minus1");
        for (int i = 0; i < 4; i++) run_period(rnd_c5(), "c5_fresh_lock");

        rise("before_silence");
        wait_cyc(1000);
        audio_sq = 1'b0;
        if (meas) model_timeout(last_t + 3 + CNT_MAX);
        wait_cyc(CNT_MAX + 20);
        check_state("after_silence");

        for (int i = 0; i < 5; i++) run_period(rnd_c5(), "c5_relock");
        run_period_reset(rnd_c5());
        for (int i = 0; i < 5; i++) run_period(rnd_c5(), "c5_after_reset");
        rise("final_lock");
        wait_cyc(20);
        audio_sq = 1'b0;

        while (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL missed_change: run ended, required note_array=%h at cycle %0d", sb[0].val, sb[0].cyc);
            void'(sb.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/note_detector.md
# note_detector

Measures the period of the squared-up microphone signal, classifies it into one of eight notes (C4–C5), and drives the one-hot `note_array` bus consumed by the screen mapping stage. A note is reported only after several consecutive periods agree. Silence is detected by a period timeout. It runs in the 50 MHz system clock domain, alongside the VGA stage.

## Interface
- `CNT_W`, 18 — period counter width; saturation value 2^CNT_W−1 = 262143 is the silence timeout.
- `STABLE_CNT`, 4 — consecutive same-bin periods required before the output changes (legal range 1–15).
- `clk` in 1 — 50 MHz system clock; all logic on the rising edge.
- `reset` in 1 — asynchronous, active-low reset; all state clears while low.
- `audio_sq` in 1 — asynchronous comparator output from the microphone front end.
- `note_array` out 8 — one-hot current note: bit0 C4, bit1 D4, bit2 E4, bit3 F4, bit4 G4, bit5 A4, bit6 B4, bit7 C5; 8'h00 means no note.
- `note_new` out 1 — one-cycle pulse whenever `note_array` changes value.

## Operation
- **Input path:** `audio_sq` passes through a 2-flop synchronizer, then a registered rising-edge detect (`edge`).
- **FSM, two states:**
  - IDLE (reset state): counter held at 0. On `edge`, go to MEASURE, load counter = 1, and do not classify.
  - MEASURE: the counter increments each cycle and saturates at 262143.
    - On `edge`: P = counter value, which equals the clocks between edges. Classify P, then reload counter = 1.
    - If the counter reaches saturation with no `edge`: timeout. Go to IDLE, clear the candidate and the match count.
- **Bins, half-open [lo, hi), 50 MHz constants:**
  - C4 [180689, 201537)
  - D4 [160975, 180689)
  - E4 [147428, 160975)
  - F4 [135361, 147428)
  - G4 [120593, 135361)
  - A4 [107437, 120593)
  - B4 [98397, 107437)
  - C5 [92715, 98397)
  - Any other P is out of range.
- **Stability filter:**
  - Bin equals the candidate: the match count increments and saturates at `STABLE_CNT`.
  - Bin differs: candidate = bin, count = 1.
  - Out of range: candidate = none, count = 0. The output is unchanged.
- **Output update:** when count reaches `STABLE_CNT` and the candidate's one-hot differs from `note_array`, load `note_array` and pulse `note_new`.
- **Timeout:** output behaviour is set by the Configuration macro.
- **Simultaneous events:** `edge` in the same cycle as saturation counts as an edge. P = 262143 is out of range, so no timeout fires.

## Timing
- **Reset values:** `note_array` = 8'h00, `note_new` = 0, FSM IDLE, counter 0, candidate none, count 0.
- **Latency:**
  - `edge` is asserted 3 clk cycles after `audio_sq` is first sampled high.
  - `note_array` and `note_new` change on the cycle after the qualifying `edge`, so 4 cycles from the pin.
  - On timeout, outputs change the cycle after saturation is reached.
- **`note_new`:** high for exactly one cycle and never asserts for an unchanged value.
- **Reset mid-period:** immediate asynchronous return to reset values. The first edge after release only starts a measurement.

## Configuration
- `NOTE_HOLD_EN` defined: timeout leaves `note_array` unchanged and raises no `note_new`. The last note stays displayed until a different stable note is detected.
- Not defined (default): timeout clears `note_array` to 8'h00 and pulses `note_new` if the value was nonzero.

## Test plan
- **Reset:** hold `reset` = 0 with `audio_sq` toggling → `note_array` = 8'h00, `note_new` = 0 throughout; the first edge after release produces no classification.
- **Lock to A4:** square wave with period 113636 clks → `note_array` goes 8'h00 → 8'h20 exactly 4 cycles after the 5th rising edge (4th measured period), with one `note_new` pulse.
- **Note change A4 → C5:** switch to period 95556 → stays 8'h20 for 3 periods, becomes 8'h80 after the 4th, with a single `note_new` pulse.
- **Bin boundaries:** periods of 180689 → 8'h01; 180688 → 8'h02; 92714 or 50000 → output unchanged and match count cleared (an A4 lock needs 4 fresh periods).
- **Silence:** stop toggling after an A4 lock.
  - Default build: `note_array` = 8'h00 and `note_new` pulses 262143 cycles after the last edge.
  - With `NOTE_HOLD_EN`: stays 8'h20 with no pulse.
- **Reset mid-operation:** assert `reset` for 1 cycle during a C5 lock → outputs clear immediately; relock to 8'h80 needs 5 more rising edges.
